// File: rtl/ace_ccu_snoop_mux_bcast_if.sv
// Snoop-side bundle of the CCU snoop dispatch stage: initiator AC/CR channels and snooper AC/CR channels.
// The slave modport is the dispatch stage; the master modport is the surrounding controllers and caches.
interface ace_ccu_snoop_mux_bcast_if #(
    parameter int unsigned NoInitiators = 2,
    parameter int unsigned NoSnoopers   = 4,
    parameter int unsigned AddrWidth    = 64
);
    logic [NoInitiators-1:0]            ini_ac_valid_i;
    logic [NoInitiators-1:0]            ini_ac_ready_o;
    logic [NoInitiators*AddrWidth-1:0]  ini_ac_addr_i;
    logic [NoInitiators*4-1:0]          ini_ac_snoop_i;
    logic [NoInitiators*3-1:0]          ini_ac_prot_i;
    logic [NoInitiators*NoSnoopers-1:0] ini_mask_i;
    logic [NoInitiators-1:0]            ini_cr_valid_o;
    logic [NoInitiators-1:0]            ini_cr_ready_i;
    logic [NoInitiators*5-1:0]          ini_cr_resp_o;
    logic [NoSnoopers-1:0]              snp_ac_valid_o;
    logic [NoSnoopers-1:0]              snp_ac_ready_i;
    logic [AddrWidth-1:0]               snp_ac_addr_o;
    logic [3:0]                         snp_ac_snoop_o;
    logic [2:0]                         snp_ac_prot_o;
    logic [NoSnoopers-1:0]              snp_cr_valid_i;
    logic [NoSnoopers-1:0]              snp_cr_ready_o;
    logic [NoSnoopers*5-1:0]            snp_cr_resp_i;

    modport slave (
        input  ini_ac_valid_i, ini_ac_addr_i, ini_ac_snoop_i, ini_ac_prot_i, ini_mask_i,
        input  ini_cr_ready_i, snp_ac_ready_i, snp_cr_valid_i, snp_cr_resp_i,
        output ini_ac_ready_o, ini_cr_valid_o, ini_cr_resp_o,
        output snp_ac_valid_o, snp_ac_addr_o, snp_ac_snoop_o, snp_ac_prot_o, snp_cr_ready_o
    );

    modport master (
        output ini_ac_valid_i, ini_ac_addr_i, ini_ac_snoop_i, ini_ac_prot_i, ini_mask_i,
        output ini_cr_ready_i, snp_ac_ready_i, snp_cr_valid_i, snp_cr_resp_i,
        input  ini_ac_ready_o, ini_cr_valid_o, ini_cr_resp_o,
        input  snp_ac_valid_o, snp_ac_addr_o, snp_ac_snoop_o, snp_ac_prot_o, snp_cr_ready_o
    );
endinterface

// File: rtl/ace_ccu_snoop_mux_bcast.sv
// CCU snoop dispatch: round-robin AC arbitration, masked broadcast to snoopers, in-order OR-merge of CR.
// Defining CCU_SNOOP_PERF_EN adds saturating merged-CR / DataTransfer counters (perf_snoops_o, perf_dt_o).
module ace_ccu_snoop_mux_bcast #(
    parameter int unsigned NoInitiators = 2,
    parameter int unsigned NoSnoopers   = 4,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned MaxTrans     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ace_ccu_snoop_mux_bcast_if.slave bus
`ifdef CCU_SNOOP_PERF_EN
    ,
    output logic [31:0]              perf_snoops_o,
    output logic [31:0]              perf_dt_o
`endif
);

    localparam int unsigned IdxW = (NoInitiators > 1) ? $clog2(NoInitiators) : 1;
    localparam int unsigned PtrW = $clog2(MaxTrans);

    typedef enum logic {
        IDLE,
        BCAST
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    logic [IdxW-1:0]        win;
    logic                   win_found;
    int unsigned            idx;
    logic                   ac_hs;
    logic [NoSnoopers-1:0]  win_mask;
    logic [AddrWidth-1:0]   win_addr;
    logic [3:0]             win_snoop;
    logic [2:0]             win_prot;
    logic [NoInitiators-1:0] ac_ready;

    logic [AddrWidth-1:0]   addr_q;
    logic [3:0]             snoop_q;
    logic [2:0]             prot_q;
    logic [NoSnoopers-1:0]  pend_q, pend_d;

    logic [IdxW-1:0]        fifo_ini_q  [MaxTrans];
    logic [NoSnoopers-1:0]  fifo_mask_q [MaxTrans];
    logic [PtrW:0]          wr_q, rd_q;
    logic                   full, empty;
    logic [IdxW-1:0]        head_ini;
    logic [NoSnoopers-1:0]  head_mask;

    logic [NoSnoopers-1:0]  got_q, got_d;
    logic [4:0]             acc_q, acc_d;
    logic [NoSnoopers-1:0]  cr_ready, cr_hs;
    logic                   cr_done, pop;
    logic [NoInitiators-1:0]   cr_valid;
    logic [NoInitiators*5-1:0] cr_resp;

    assign full      = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign empty     = (wr_q == rd_q);
    assign head_ini  = fifo_ini_q[rd_q[PtrW-1:0]];
    assign head_mask = fifo_mask_q[rd_q[PtrW-1:0]];

    // First valid initiator at or after the RR pointer wins.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NoInitiators; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NoInitiators) idx = idx - NoInitiators;
            if (!win_found && bus.ini_ac_valid_i[idx]) begin
                win       = IdxW'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign win_mask  = bus.ini_mask_i[32'(win)*NoSnoopers +: NoSnoopers];
    assign win_addr  = bus.ini_ac_addr_i[32'(win)*AddrWidth +: AddrWidth];
    assign win_snoop = bus.ini_ac_snoop_i[32'(win)*4 +: 4];
    assign win_prot  = bus.ini_ac_prot_i[32'(win)*3 +: 3];
    assign ac_hs     = rst_ni && (state_q == IDLE) && !full && win_found;

    always_comb begin
        ac_ready = '0;
        if (ac_hs) ac_ready[win] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (ac_hs) begin
                    pend_d = win_mask;
                    if (32'(win) == NoInitiators - 1) rr_d = '0;
                    else                              rr_d = win + 1'b1;
                    if (win_mask != '0) state_d = BCAST;
                end
            end
            BCAST: begin
                pend_d = pend_q & ~bus.snp_ac_ready_i;
                if (pend_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            snoop_q <= '0;
            prot_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            if (ac_hs) begin
                addr_q  <= win_addr;
                snoop_q <= win_snoop;
                prot_q  <= win_prot;
            end
        end
    end

    // Tracking FIFO keeps global AC order; its head owns the CR collector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned m = 0; m < MaxTrans; m++) begin
                fifo_ini_q[m]  <= '0;
                fifo_mask_q[m] <= '0;
            end
        end else begin
            if (ac_hs) begin
                fifo_ini_q[wr_q[PtrW-1:0]]  <= win;
                fifo_mask_q[wr_q[PtrW-1:0]] <= win_mask;
                wr_q                        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_comb begin
        cr_ready = '0;
        if (!empty) cr_ready = head_mask & ~got_q;
        cr_hs   = cr_ready & bus.snp_cr_valid_i;
        cr_done = !empty && (got_q == head_mask);
        pop     = cr_done && bus.ini_cr_ready_i[head_ini];
        acc_d   = acc_q;
        for (int unsigned j = 0; j < NoSnoopers; j++) begin
            if (cr_hs[j]) acc_d = acc_d | bus.snp_cr_resp_i[j*5 +: 5];
        end
        got_d = got_q | cr_hs;
        if (pop) begin
            got_d = '0;
            acc_d = '0;
        end
        cr_valid = '0;
        cr_resp  = '0;
        if (cr_done) begin
            cr_valid[head_ini]              = 1'b1;
            cr_resp[32'(head_ini)*5 +: 5]   = acc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            got_q <= '0;
            acc_q <= '0;
        end else begin
            got_q <= got_d;
            acc_q <= acc_d;
        end
    end

    assign bus.ini_ac_ready_o = ac_ready;
    assign bus.snp_ac_valid_o = (state_q == BCAST) ? pend_q : '0;
    assign bus.snp_ac_addr_o  = addr_q;
    assign bus.snp_ac_snoop_o = snoop_q;
    assign bus.snp_ac_prot_o  = prot_q;
    assign bus.snp_cr_ready_o = cr_ready;
    assign bus.ini_cr_valid_o = cr_valid;
    assign bus.ini_cr_resp_o  = cr_resp;

`ifdef CCU_SNOOP_PERF_EN
    logic [31:0] perf_snoops_q, perf_dt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_snoops_q <= '0;
            perf_dt_q     <= '0;
        end else if (pop) begin
            if (perf_snoops_q != '1)           perf_snoops_q <= perf_snoops_q + 1'b1;
            if (acc_q[0] && perf_dt_q != '1)   perf_dt_q     <= perf_dt_q + 1'b1;
        end
    end

    assign perf_snoops_o = perf_snoops_q;
    assign perf_dt_o     = perf_dt_q;
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_mux_bcast.sv
// Randomized bench for ace_ccu_snoop_mux_bcast against a transaction-queue reference model.
module tb_ace_ccu_snoop_mux_bcast;
    localparam int unsigned NI = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned MT = 4;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ace_ccu_snoop_mux_bcast_if #(.NoInitiators(NI), .NoSnoopers(NS), .AddrWidth(AW)) bus_if ();

`ifdef CCU_SNOOP_PERF_EN
    logic [31:0] perf_snoops, perf_dt;
    int unsigned m_snoops, m_dt;
`endif

    ace_ccu_snoop_mux_bcast #(
        .NoInitiators(NI),
        .NoSnoopers  (NS),
        .AddrWidth   (AW),
        .MaxTrans    (MT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_if)
`ifdef CCU_SNOOP_PERF_EN
        ,
        .perf_snoops_o(perf_snoops),
        .perf_dt_o    (perf_dt)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: one record per accepted snoop, oldest first.
    typedef struct {
        int unsigned        id;
        int unsigned        ini;
        logic [NS-1:0]      mask;
        logic [NS-1:0]      dlv;
        logic [NS-1:0]      got;
        logic [4:0]         acc;
        logic [NS-1:0][4:0] rsp;
    } txn_t;

    txn_t          txnq[$];
    int unsigned   next_id, rr;
    logic          busy;
    logic [NS-1:0] bz_pend;
    int unsigned   bz_id;
    logic [AW-1:0] bz_addr;
    logic [3:0]    bz_snoop;
    logic [2:0]    bz_prot;

    logic [NI-1:0]    iv, crr;
    logic [NI*AW-1:0] ia;
    logic [NI*4-1:0]  isn;
    logic [NI*3-1:0]  ipr;
    logic [NI*NS-1:0] imk;
    logic [NS-1:0]    sar, crv;
    logic [NS*5-1:0]  crs;

    logic [NI-1:0]   exp_acr, exp_civ;
    logic [NS-1:0]   exp_acv, exp_crr;
    logic [NI*5-1:0] exp_resp;
    int unsigned     exp_win;

    int unsigned p_iv, p_acr, p_crv, p_icr, mmode;

    function automatic bit pct(input int unsigned p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic logic [NS-1:0] gen_mask();
        if (mmode == 1) return '1;
        if (mmode == 2) return pct(50) ? '0 : NS'($urandom_range(1, (1 << NS) - 1));
        return NS'($urandom_range(0, (1 << NS) - 1));
    endfunction

    function automatic int front_idx(input int unsigned j);
        for (int unsigned k = 0; k < txnq.size(); k++)
            if (txnq[k].dlv[j] && !txnq[k].got[j]) return int'(k);
        return -1;
    endfunction

    function automatic int find_id(input int unsigned id);
        for (int unsigned k = 0; k < txnq.size(); k++)
            if (txnq[k].id == id) return int'(k);
        return -1;
    endfunction

    task automatic push_bus();
        bus_if.ini_ac_valid_i = iv;
        bus_if.ini_ac_addr_i  = ia;
        bus_if.ini_ac_snoop_i = isn;
        bus_if.ini_ac_prot_i  = ipr;
        bus_if.ini_mask_i     = imk;
        bus_if.ini_cr_ready_i = crr;
        bus_if.snp_ac_ready_i = sar;
        bus_if.snp_cr_valid_i = crv;
        bus_if.snp_cr_resp_i  = crs;
    endtask

    task automatic drive_inputs();
        int k;
        for (int unsigned i = 0; i < NI; i++) begin
            if (!iv[i] && pct(p_iv)) begin
                iv[i]           = 1'b1;
                ia[i*AW +: AW]  = {$urandom(), $urandom()};
                isn[i*4 +: 4]   = 4'($urandom_range(0, 15));
                ipr[i*3 +: 3]   = 3'($urandom_range(0, 7));
                imk[i*NS +: NS] = gen_mask();
            end
            crr[i] = pct(p_icr);
        end
        for (int unsigned j = 0; j < NS; j++) begin
            sar[j] = pct(p_acr);
            k = front_idx(j);
            if (k < 0) begin
                crv[j] = 1'b0;
            end else begin
                if (!crv[j] && pct(p_crv)) crv[j] = 1'b1;
                crs[j*5 +: 5] = txnq[k].rsp[j];
            end
        end
        push_bus();
    endtask

    task automatic compute_and_check();
        exp_acr  = '0;
        exp_win  = 0;
        exp_acv  = busy ? bz_pend : '0;
        exp_crr  = '0;
        exp_civ  = '0;
        exp_resp = '0;
        if (!busy && txnq.size() < MT) begin
            for (int unsigned k = 0; k < NI; k++) begin
                if (exp_acr == '0 && iv[(rr + k) % NI]) begin
                    exp_win          = (rr + k) % NI;
                    exp_acr[exp_win] = 1'b1;
                end
            end
        end
        if (txnq.size() > 0) begin
            exp_crr = txnq[0].mask & ~txnq[0].got;
            if (txnq[0].got == txnq[0].mask) begin
                exp_civ[txnq[0].ini]          = 1'b1;
                exp_resp[txnq[0].ini*5 +: 5]  = txnq[0].acc;
            end
        end
        check_eq("ini_ac_ready", 64'(bus_if.ini_ac_ready_o), 64'(exp_acr));
        check_eq("snp_ac_valid", 64'(bus_if.snp_ac_valid_o), 64'(exp_acv));
        check_eq("snp_cr_ready", 64'(bus_if.snp_cr_ready_o), 64'(exp_crr));
        check_eq("ini_cr_valid", 64'(bus_if.ini_cr_valid_o), 64'(exp_civ));
        check_eq("ini_cr_resp",  64'(bus_if.ini_cr_resp_o),  64'(exp_resp));
        if (busy) begin
            check_eq("snp_ac_addr",  bus_if.snp_ac_addr_o,        bz_addr);
            check_eq("snp_ac_snoop", 64'(bus_if.snp_ac_snoop_o), 64'(bz_snoop));
            check_eq("snp_ac_prot",  64'(bus_if.snp_ac_prot_o),  64'(bz_prot));
        end
    endtask

    task automatic update_model();
        txn_t t;
        int   k;
        if (txnq.size() > 0) begin
            t = txnq[0];
            for (int unsigned j = 0; j < NS; j++) begin
                if (crv[j] && exp_crr[j]) begin
                    t.got[j] = 1'b1;
                    t.acc    = t.acc | t.rsp[j];
                    crv[j]   = 1'b0;
                end
            end
            txnq[0] = t;
        end
        if (exp_civ != '0 && crr[txnq[0].ini]) begin
`ifdef CCU_SNOOP_PERF_EN
            m_snoops++;
            if (txnq[0].acc[0]) m_dt++;
`endif
            void'(txnq.pop_front());
        end
        if (busy) begin
            k = find_id(bz_id);
            if (k >= 0) begin
                t = txnq[k];
                for (int unsigned j = 0; j < NS; j++) begin
                    if (bz_pend[j] && sar[j]) begin
                        t.dlv[j]   = 1'b1;
                        t.rsp[j]   = 5'($urandom_range(0, 31));
                        bz_pend[j] = 1'b0;
                    end
                end
                txnq[k] = t;
            end
            if (bz_pend == '0) busy = 1'b0;
        end
        if (exp_acr != '0) begin
            t.id   = next_id;
            t.ini  = exp_win;
            t.mask = imk[exp_win*NS +: NS];
            t.dlv  = '0;
            t.got  = '0;
            t.acc  = '0;
            t.rsp  = '0;
            txnq.push_back(t);
            rr = (exp_win + 1) % NI;
            if (t.mask != '0) begin
                busy     = 1'b1;
                bz_pend  = t.mask;
                bz_id    = next_id;
                bz_addr  = ia[exp_win*AW +: AW];
                bz_snoop = isn[exp_win*4 +: 4];
                bz_prot  = ipr[exp_win*3 +: 3];
            end
            next_id++;
            iv[exp_win] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive_inputs();
        #1;
        compute_and_check();
        @(posedge clk);
        update_model();
    endtask

    task automatic run_phase(input int unsigned cycles, input int unsigned piv, input int unsigned pacr,
                             input int unsigned pcrv, input int unsigned picr, input int unsigned mm);
        p_iv  = piv;
        p_acr = pacr;
        p_crv = pcrv;
        p_icr = picr;
        mmode = mm;
        repeat (cycles) step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        iv  = '0;
        crr = '0;
        sar = '0;
        crv = '0;
        push_bus();
        rst_n = 1'b0;
        #1;
        check_eq("rst_ini_ac_ready", 64'(bus_if.ini_ac_ready_o), 64'h0);
        check_eq("rst_snp_ac_valid", 64'(bus_if.snp_ac_valid_o), 64'h0);
        check_eq("rst_ini_cr_valid", 64'(bus_if.ini_cr_valid_o), 64'h0);
        check_eq("rst_snp_cr_ready", 64'(bus_if.snp_cr_ready_o), 64'h0);
        check_eq("rst_ini_cr_resp",  64'(bus_if.ini_cr_resp_o),  64'h0);
        check_eq("rst_snp_ac_addr",  bus_if.snp_ac_addr_o,       64'h0);
        check_eq("rst_snp_ac_snoop", 64'(bus_if.snp_ac_snoop_o), 64'h0);
        check_eq("rst_snp_ac_prot",  64'(bus_if.snp_ac_prot_o),  64'h0);
`ifdef CCU_SNOOP_PERF_EN
        check_eq("rst_perf_snoops", 64'(perf_snoops), 64'h0);
        check_eq("rst_perf_dt",     64'(perf_dt),     64'h0);
        m_snoops = 0;
        m_dt     = 0;
`endif
        txnq.delete();
        busy    = 1'b0;
        bz_pend = '0;
        rr      = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        iv      = '0;
        ia      = '0;
        isn     = '0;
        ipr     = '0;
        imk     = '0;
        crr     = '0;
        sar     = '0;
        crv     = '0;
        crs     = '0;
        next_id = 0;
        push_bus();
        apply_reset();

        run_phase(200, 100, 100, 100, 100, 1);
        run_phase(60,  100, 100, 0,   100, 0);
        run_phase(600, 60,  50,  50,  50,  0);
        run_phase(300, 70,  60,  60,  40,  2);
        run_phase(40,  100, 100, 0,   100, 0);
        apply_reset();
        run_phase(400, 50,  40,  50,  60,  0);
`ifdef CCU_SNOOP_PERF_EN
        @(negedge clk);
        check_eq("perf_snoops", 64'(perf_snoops), 64'(m_snoops));
        check_eq("perf_dt",     64'(perf_dt),     64'(m_dt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ace_ccu_snoop_mux_bcast.md
Name: ace_ccu_snoop_mux_bcast

Overview:
- Generalised snoop dispatch stage for the CCU. It sits between NoInitiators snoop-issuing controllers (R/W snoop controllers, more in later configs) and NoSnoopers cache snoop ports.
- Round-robin arbitrates AC requests and broadcasts each winner to the snoopers selected by its domain mask.
- Collects and OR-merges the in-order CR responses and returns the merged CR to the originating initiator.
- CD data is out of scope and is handled by a separate block.

Parameters:
- NoInitiators, 2, number of snoop-issuing controllers (>=1)
- NoSnoopers, 4, number of snooped cache ports (>=1)
- AddrWidth, 64, AC address width
- MaxTrans, 4, max snoops outstanding (issued, CR not yet returned); power of two, >=2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ini_ac_valid_i  in  NoInitiators  per-initiator AC valid
- ini_ac_ready_o  out  NoInitiators  per-initiator AC ready
- ini_ac_addr_i  in  NoInitiators*AddrWidth  AC address, packed
- ini_ac_snoop_i  in  NoInitiators*4  ACSNOOP
- ini_ac_prot_i  in  NoInitiators*3  ACPROT
- ini_mask_i  in  NoInitiators*NoSnoopers  target snooper mask, sampled with AC
- ini_cr_valid_o  out  NoInitiators  merged CR valid
- ini_cr_ready_i  in  NoInitiators  merged CR ready
- ini_cr_resp_o  out  NoInitiators*5  merged CRRESP
- snp_ac_valid_o  out  NoSnoopers  AC valid per snooper
- snp_ac_ready_i  in  NoSnoopers  AC ready per snooper
- snp_ac_addr_o  out  AddrWidth  broadcast AC address
- snp_ac_snoop_o  out  4  broadcast ACSNOOP
- snp_ac_prot_o  out  3  broadcast ACPROT
- snp_cr_valid_i  in  NoSnoopers  CR valid
- snp_cr_ready_o  out  NoSnoopers  CR ready
- snp_cr_resp_i  in  NoSnoopers*5  CRRESP: [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique

Behaviour:
- Reset: all valid/ready outputs 0; snp_ac_addr/snoop/prot 0; ini_cr_resp_o 0; RR pointer 0; FIFO empty; all pending/accumulator state cleared. Reset mid-operation discards everything and applies no drain.
- AC stage FSM:
  - IDLE:
    - ini_ac_ready_o[i] = 1 only for the RR winner, and only while the FIFO is not full.
    - On handshake: register addr/snoop/prot; set pend = mask; push {ini_idx, mask} to the tracking FIFO.
    - Advance the RR pointer to winner+1 (mod NoInitiators).
    - Go to BCAST if mask != 0; otherwise stay in IDLE.
  - BCAST:
    - snp_ac_valid_o = pend.
    - Each snp_ac_ready_i[j] handshake clears pend[j]. Snoopers may accept in different cycles.
    - Fields stay stable until pend == 0, then go to IDLE. No new accept in the same cycle (1 idle cycle between broadcasts).
  - Latency: initiator handshake at cycle t gives snp_ac_valid_o at t+1.
- Tracking FIFO:
  - Depth MaxTrans. An entry is pushed at AC accept and popped at merged-CR handshake.
  - Full blocks all ini_ac_ready_o.
  - Pointer wrap uses an extra MSB bit to distinguish full from empty.
- CR collection (head entry only):
  - snp_cr_ready_o[j] = 1 iff FIFO non-empty, head.mask[j] = 1, and got[j] = 0.
  - CR from a snooper not in the head mask is back-pressured. This is deadlock-free because each snooper returns CR in AC order.
  - On accept: got[j] = 1 and acc |= snp_cr_resp_i[j].
  - Complete when got == head.mask. A mask of 0 completes immediately with acc = 0.
  - ini_cr_valid_o[head.ini] = 1 with ini_cr_resp_o[head.ini] = acc, registered, starting the cycle after the last CR accept. Other initiators' resp slices stay 0.
  - On ini_cr_ready_i handshake: pop, clear got/acc; the next head can accept CR the following cycle.
- Simultaneous push and pop on a full FIFO: the pop frees no slot for the same-cycle push. Ready is computed from registered full only.
- Same initiator: responses are returned strictly in its issue order. Across initiators, global AC order applies.

Optional Feature:
- Macro CCU_SNOOP_PERF_EN.
- Defined: adds outputs perf_snoops_o[31:0] and perf_dt_o[31:0], both reset to 0.
  - perf_snoops_o counts merged-CR handshakes.
  - perf_dt_o counts merged-CR handshakes with resp[0] = 1.
  - Both saturate at 0xFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- NoInitiators=2, NoSnoopers=4. Ini0 AC addr 0x1000, mask 4'b0110. Snooper1 ready at t+1, snooper2 at t+3.
  -> snp_ac_valid_o goes 0110, 0100, 0000; CR resp 5'b00001 | 5'b01000 gives ini_cr_resp_o[0] = 5'b01001, single-beat handshake.
- Both initiators valid every cycle, all masks 4'b1111, snoopers always ready.
  -> winners alternate 0,1,0,1; each CR is returned to the correct initiator in order.
- mask 4'b0000 from ini1.
  -> no snp_ac_valid_o pulse; ini_cr_valid_o[1] with resp 0 on the cycle after accept.
- MaxTrans=4, snoopers never return CR.
  -> exactly 4 ACs accepted, then ini_ac_ready_o = 0; one CR set completes -> ready returns.
- Snooper3 presents CR while head mask = 4'b0001.
  -> snp_cr_ready_o[3] = 0 until head advances to an entry containing snooper3.
- rst_ni asserted with 2 entries outstanding.
  -> all valids 0 immediately; after release FIFO empty, perf counters 0 (if CCU_SNOOP_PERF_EN).
